// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester, load/store requester and
// memory-side signals of the memory-port arbiter.
//   slave  - arbiter side (takes requests and memory responses, drives
//            completions and the memory request)
//   master - environment side (core requesters plus memory model)
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
) ();

  // Instruction-fetch requester
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_done;
  logic            if_err;

  // Load/store requester
  logic            ls_req;
  logic            ls_we;
  logic [3:0]      ls_be;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic [XLEN-1:0] ls_rdata;
  logic            ls_done;
  logic            ls_err;

  // Memory port
  logic            mem_req;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  // Current or last grant: 0 = IF, 1 = LS
  logic            owner;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_done, if_err,
    output ls_rdata, ls_done, ls_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output owner
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_done, if_err,
    input  ls_rdata, ls_done, ls_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and
// load/store (LS). One access in flight at a time; ties go to whichever
// requester did not win last. Each access runs IDLE -> BUSY -> RESP, with a
// one-cycle done pulse (and timeout flag) to the owner in RESP.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: IF request/response, LS request/response,
//           memory request/response and the owner indication
//
// Parameters:
//   XLEN    - address/data width
//   TIMEOUT - wait cycles before an access is aborted with err; 0 disables
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TimeoutEn  = (TIMEOUT != 0);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            grant_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= 1'b1;  // first tie goes to IF
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // LS wins when it is the only requester, or on a tie when IF owned last.
  assign grant_ls = bus.ls_req && (!bus.if_req || !owner_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.ls_req) begin
          owner_d = grant_ls;
          if (grant_ls) begin
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
            mem_be_d    = bus.ls_be;
            mem_we_d    = bus.ls_we;
          end else begin
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
            mem_we_d    = 1'b0;
          end
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        // mem_ready takes priority over a coincident timeout.
        if (bus.mem_ready) begin
          if (!mem_we_q) begin
            if (owner_q) ls_rdata_d = bus.mem_rdata;
            else         if_rdata_d = bus.mem_rdata;
          end
          state_d = StResp;
        end else if (TimeoutEn && (cnt_q == TimeoutCnt)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StResp: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.mem_req   = (state_q == StBusy);
  // Write strobe only while the access is on the bus.
  assign bus.mem_we    = mem_we_q && (state_q == StBusy);
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_done   = (state_q == StResp) && !owner_q;
  assign bus.ls_done   = (state_q == StResp) && owner_q;
  assign bus.if_err    = bus.if_done && err_q;
  assign bus.ls_err    = bus.ls_done && err_q;
  assign bus.owner     = owner_q;

endmodule
